ttc3_cmd_arbiter: RTL
=====================

// Module: ttc3_cmd_arbiter
// PURPOSE
//  Multi-requester front-end for the TTC3 command interface. Buffers commands from NUM_CH
//  independent channels in per-channel FIFOs and arbitrates them round-robin onto the single
//  core cmd/resp port, keeping one command outstanding. Routes each response back to the
//  issuing channel. Sits between the SoC requesters and ttc3_top.
// PARAMETERS
//  NUM_CH      4    number of requester channels (>=1)
//  FIFO_DEPTH  4    entries per channel FIFO (power of two, >=2)
//  OP_WIDTH    3    command opcode width
//  DATA_WIDTH  512  command/response payload width
// PORTS
//  clock            in   1                    single clock, rising edge
//  reset            in   1                    asynchronous, active-high
//  ch_cmd_valid     in   NUM_CH               per-channel command valid
//  ch_cmd_ready     out  NUM_CH               per-channel FIFO not full
//  ch_cmd_op        in   NUM_CH*OP_WIDTH      per-channel opcode, channel i at [i*OP_WIDTH +: OP_WIDTH]
//  ch_cmd_data      in   NUM_CH*DATA_WIDTH    per-channel payload
//  ch_resp_valid    out  NUM_CH               one-hot, single-cycle response strobe
//  ch_resp_data     out  DATA_WIDTH           shared response data, qualified by ch_resp_valid
//  ch_resp_err      out  1                    response is an error (denied op)
//  core_cmd_valid   out  1                    command to core
//  core_cmd_ready   in   1                    core accepts command
//  core_cmd_op      out  OP_WIDTH             opcode to core
//  core_cmd_data    out  DATA_WIDTH           payload to core
//  core_resp_valid  in   1                    core response strobe
//  core_resp_data   in   DATA_WIDTH           core response data
//  stray_resp       out  1                    sticky: core_resp_valid seen outside WAIT
// BEHAVIOUR
//  - Reset: all FIFOs empty, FSM IDLE, rr pointer = NUM_CH-1 (ch0 served first); all outputs 0,
//    except ch_cmd_ready = all ones once reset is deasserted. An in-flight core command is
//    discarded; the core is reset on the same reset.
//  - Push on ch_cmd_valid[i] & ch_cmd_ready[i]. ch_cmd_ready[i] = !full[i], no bypass path.
//  - FIFO pointers are $clog2(FIFO_DEPTH)+1 bits and wrap naturally.
//  - FSM:
//      IDLE:  if any FIFO is non-empty, grant the first non-empty channel after the rr
//             pointer (wrapping NUM_CH-1 to 0). Pop its head into the hold register and set
//             rr pointer = grant. Then:
//               op == OP_NOP  -> LOCAL
//               op denied     -> DENY
//               otherwise     -> ISSUE
//      ISSUE: core_cmd_valid = 1; op/data held stable until core_cmd_ready; on handshake -> WAIT.
//      WAIT:  on core_resp_valid, register data and pulse ch_resp_valid[grant] the next cycle
//             -> IDLE.
//      LOCAL: pulse ch_resp_valid[grant] with data 0, err 0; no core transaction -> IDLE.
//      DENY:  pulse ch_resp_valid[grant] with data 0, err 1 -> IDLE.
//  - Latency: core_cmd_valid rises 1 cycle after the push edge when IDLE with empty FIFOs.
//    ch_resp_valid rises 1 cycle after core_resp_valid. A LOCAL response arrives 2 cycles
//    after the push edge.
//  - ch_resp_data and ch_resp_err are 0 whenever ch_resp_valid == 0.
//  - core_resp_valid outside WAIT is ignored and sets stray_resp (cleared only by reset).
//  - A push and a pop on the same FIFO in the same cycle are both honoured.
//  - NUM_CH == 1: grant is always 0.
// CONFIGURATION
//  ACCESS_CTRL_EN defined:
//   - Adds ports: cfg_perm_we (in, 1), cfg_perm_ch (in, $clog2(NUM_CH) bits, minimum 1),
//     cfg_perm_mask (in, 2**OP_WIDTH).
//   - The write stores a per-channel allowed-op mask register; reset value is all ones.
//   - Op k is denied for channel c when mask[c][k] == 0. The check uses the mask value at
//     pop time.
//  ACCESS_CTRL_EN undefined: the cfg ports are absent, DENY is unreachable,
//  ch_resp_err is tied to 0.
// STRUCTURE
//  - Package ttc3_pkg: OP_* opcode localparams (NOP=0, GET_ID=1, SHA256=2, HMAC=3,
//    AES_CTR=4, DERIVE_KEY=5) and the FSM state enum arb_state_t.
//  - Sub-module ttc3_cmd_fifo: sync FIFO {op, data}, parameters DEPTH/WIDTH,
//    full/empty/push/pop; one instance per channel via generate.
//  - Arbiter, hold register and FSM live in this module.
// TESTING
//  1. ch1 pushes GET_ID -> next cycle core_cmd_valid=1, op=3'b001. Core returns
//     0x...ABCD -> next cycle ch_resp_valid=4'b0010, data 0x...ABCD, err 0.
//  2. All 4 channels push SHA256 in the same cycle -> core sees channels 0,1,2,3 in order.
//     Then ch0 and ch2 push -> order 0,2.
//  3. core_cmd_ready held 0; ch0 pushes until ch_cmd_ready[0] falls -> exactly 5 accepted
//     (1 in hold, 4 in FIFO). Release -> 5 responses in push order.
//  4. ch3 pushes OP_NOP -> ch_resp_valid=4'b1000 2 cycles after push, data 0;
//     core_cmd_valid never rises.
//  5. Assert reset while in WAIT -> all outputs 0 asynchronously. After release, ch0 and
//     ch1 push together -> ch0 granted first.
//     Also: core_resp_valid pulsed while IDLE -> stray_resp=1 and stays set.
//  6. ACCESS_CTRL_EN: write ch2 mask=8'b1101_1111 -> ch2 DERIVE_KEY gets err=1, data 0,
//     no core command. ch1 DERIVE_KEY is forwarded to the core.

Source files
------------

// File: rtl/ttc3_pkg.sv
// Shared TTC3 opcodes and the command-arbiter FSM state type.
package ttc3_pkg;

  localparam int unsigned OP_NOP        = 0;
  localparam int unsigned OP_GET_ID     = 1;
  localparam int unsigned OP_SHA256     = 2;
  localparam int unsigned OP_HMAC       = 3;
  localparam int unsigned OP_AES_CTR    = 4;
  localparam int unsigned OP_DERIVE_KEY = 5;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StLocal,
    StDeny
  } arb_state_t;

endpackage

// File: rtl/ttc3_cmd_fifo.sv
// Per-channel synchronous command FIFO; extra pointer MSB separates full from empty.
module ttc3_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/ttc3_cmd_arbiter.sv
// Round-robin front-end: per-channel FIFOs onto the single TTC3 core port, one command in flight.
// Define ACCESS_CTRL_EN to add per-channel allowed-opcode masks and the DENY response path.
module ttc3_cmd_arbiter
  import ttc3_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned OP_WIDTH   = 3,
  parameter int unsigned DATA_WIDTH = 512
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic [NUM_CH-1:0]            i_ch_cmd_valid,
  output logic [NUM_CH-1:0]            o_ch_cmd_ready,
  input  logic [NUM_CH*OP_WIDTH-1:0]   i_ch_cmd_op,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_ch_cmd_data,
  output logic [NUM_CH-1:0]            o_ch_resp_valid,
  output logic [DATA_WIDTH-1:0]        o_ch_resp_data,
  output logic                         o_ch_resp_err,
  output logic                         o_core_cmd_valid,
  input  logic                         i_core_cmd_ready,
  output logic [OP_WIDTH-1:0]          o_core_cmd_op,
  output logic [DATA_WIDTH-1:0]        o_core_cmd_data,
  input  logic                         i_core_resp_valid,
  input  logic [DATA_WIDTH-1:0]        i_core_resp_data,
  output logic                         o_stray_resp
`ifdef ACCESS_CTRL_EN
  ,
  input  logic                                           i_cfg_perm_we,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] i_cfg_perm_ch,
  input  logic [(2**OP_WIDTH)-1:0]                       i_cfg_perm_mask
`endif
);

  localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned FW = OP_WIDTH + DATA_WIDTH;

  logic [NUM_CH-1:0]     w_full;
  logic [NUM_CH-1:0]     w_empty;
  logic [NUM_CH-1:0]     w_push;
  logic [NUM_CH-1:0]     w_pop;
  logic [FW-1:0]         w_head [NUM_CH];
  logic                  w_any;
  logic [CW-1:0]         w_grant;
  logic [OP_WIDTH-1:0]   w_head_op;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic                  w_denied;
  logic [NUM_CH-1:0]     w_grant_1h;

  arb_state_t            r_state;
  logic [CW-1:0]         r_rr;
  logic [CW-1:0]         r_grant;
  logic [OP_WIDTH-1:0]   r_hold_op;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic                  r_core_valid;
  logic [NUM_CH-1:0]     r_resp_valid;
  logic [DATA_WIDTH-1:0] r_resp_data;
  logic                  r_resp_err;
  logic                  r_stray;

  // Ready is held low for as long as reset is asserted.
  assign o_ch_cmd_ready = ~w_full & {NUM_CH{~i_reset}};
  assign w_push         = i_ch_cmd_valid & o_ch_cmd_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
    ttc3_cmd_fifo #(
      .DEPTH(FIFO_DEPTH),
      .WIDTH(FW)
    ) u_fifo (
      .i_clock(i_clock),
      .i_reset(i_reset),
      .i_push (w_push[g]),
      .i_data ({i_ch_cmd_op[g*OP_WIDTH +: OP_WIDTH], i_ch_cmd_data[g*DATA_WIDTH +: DATA_WIDTH]}),
      .i_pop  (w_pop[g]),
      .o_data (w_head[g]),
      .o_full (w_full[g]),
      .o_empty(w_empty[g])
    );
  end

  // Scan from farthest to nearest after the rr pointer so the nearest non-empty channel wins.
  always_comb begin
    logic [CW-1:0] idx;
    idx     = '0;
    w_any   = 1'b0;
    w_grant = '0;
    for (int k = int'(NUM_CH); k >= 1; k--) begin
      idx = CW'((int'(r_rr) + k) % int'(NUM_CH));
      if (!w_empty[idx]) begin
        w_any   = 1'b1;
        w_grant = idx;
      end
    end
  end

  assign w_head_op   = w_head[w_grant][FW-1 -: OP_WIDTH];
  assign w_head_data = w_head[w_grant][DATA_WIDTH-1:0];
  assign w_grant_1h  = NUM_CH'(1) << r_grant;

  always_comb begin
    w_pop = '0;
    if (r_state == StIdle && w_any) w_pop[w_grant] = 1'b1;
  end

`ifdef ACCESS_CTRL_EN
  logic [(2**OP_WIDTH)-1:0] r_perm_mask [NUM_CH];

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int c = 0; c < int'(NUM_CH); c++) r_perm_mask[c] <= '1;
    end else if (i_cfg_perm_we && (32'(i_cfg_perm_ch) < NUM_CH)) begin
      r_perm_mask[i_cfg_perm_ch] <= i_cfg_perm_mask;
    end
  end

  assign w_denied = ~r_perm_mask[w_grant][w_head_op];
`else
  assign w_denied = 1'b0;
`endif

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_rr         <= CW'(NUM_CH - 1);
      r_grant      <= '0;
      r_hold_op    <= '0;
      r_hold_data  <= '0;
      r_core_valid <= 1'b0;
      r_resp_valid <= '0;
      r_resp_data  <= '0;
      r_resp_err   <= 1'b0;
      r_stray      <= 1'b0;
    end else begin
      // Response strobe is single-cycle and its payload is zero when not strobing.
      r_resp_valid <= '0;
      r_resp_data  <= '0;
      r_resp_err   <= 1'b0;
      if (i_core_resp_valid && r_state != StWait) r_stray <= 1'b1;
      unique case (r_state)
        StIdle: begin
          if (w_any) begin
            r_grant     <= w_grant;
            r_rr        <= w_grant;
            r_hold_op   <= w_head_op;
            r_hold_data <= w_head_data;
            if (w_head_op == OP_WIDTH'(OP_NOP)) begin
              r_state <= StLocal;
            end else if (w_denied) begin
              r_state <= StDeny;
            end else begin
              r_state      <= StIssue;
              r_core_valid <= 1'b1;
            end
          end
        end
        StIssue: begin
          if (i_core_cmd_ready) begin
            r_core_valid <= 1'b0;
            r_state      <= StWait;
          end
        end
        StWait: begin
          if (i_core_resp_valid) begin
            r_resp_valid <= w_grant_1h;
            r_resp_data  <= i_core_resp_data;
            r_state      <= StIdle;
          end
        end
        StLocal: begin
          r_resp_valid <= w_grant_1h;
          r_state      <= StIdle;
        end
        StDeny: begin
          r_resp_valid <= w_grant_1h;
          r_resp_err   <= 1'b1;
          r_state      <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_core_cmd_valid = r_core_valid;
  assign o_core_cmd_op    = r_hold_op;
  assign o_core_cmd_data  = r_hold_data;
  assign o_ch_resp_valid  = r_resp_valid;
  assign o_ch_resp_data   = r_resp_data;
  assign o_ch_resp_err    = r_resp_err;
  assign o_stray_resp     = r_stray;

endmodule
